// File: rtl/regfile_if.sv
// regfile_if: bundle between the register file and its clients.
//   Write side (writeback): wenable, fmode, wreg, wdata, pcenable, next_pc
//   Read side (decode)    : enable, rs1..rs3, rs1_f..rs3_f -> done, rdata1..rdata3
//   Architectural PC      : pc
// master = client (writeback/decode), slave = regfile.
interface regfile_if;
    logic        wenable;
    logic        fmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        pcenable;
    logic [31:0] next_pc;
    logic        enable;
    logic [4:0]  rs1, rs2, rs3;
    logic        rs1_f, rs2_f, rs3_f;
    logic        done;
    logic [31:0] rdata1, rdata2, rdata3;
    logic [31:0] pc;

    modport master (
        output wenable, fmode, wreg, wdata, pcenable, next_pc,
        output enable, rs1, rs2, rs3, rs1_f, rs2_f, rs3_f,
        input  done, rdata1, rdata2, rdata3, pc
    );

    modport slave (
        input  wenable, fmode, wreg, wdata, pcenable, next_pc,
        input  enable, rs1, rs2, rs3, rs1_f, rs2_f, rs3_f,
        output done, rdata1, rdata2, rdata3, pc
    );
endinterface

// File: rtl/regfile.sv
// regfile: architectural state of the multicycle core.
//   32 x 32-bit integer bank (x0 hardwired to zero), 32 x 32-bit float bank,
//   and the program counter. One write port, three registered read ports
//   with write-first forwarding, enable/done handshake with one-cycle latency.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - regfile_if.slave (write, pc update, operand read)
// Parameter:
//   RESET_PC - value of pc after reset
module regfile #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic      clk,
    input  logic      rstn,
    regfile_if.slave  bus
);
    localparam int NPORTS = 3;

    logic [31:0] xr [32];
    logic [31:0] fr [32];

    logic [NPORTS-1:0][4:0]  rs;
    logic [NPORTS-1:0]       rs_f;
    logic [NPORTS-1:0][31:0] rd_next;
    logic [NPORTS-1:0][31:0] rdata;
    logic                    done;
    logic [31:0]             pc;

    assign rs   = {bus.rs3, bus.rs2, bus.rs1};
    assign rs_f = {bus.rs3_f, bus.rs2_f, bus.rs1_f};

    // Per-port read mux. Priority: integer x0 reads zero, then a same-edge
    // write to the same bank/index is forwarded, else the stored entry.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic is_x0;
        logic fwd;
        assign is_x0 = !rs_f[p] && (rs[p] == 5'd0);
        assign fwd   = bus.wenable && (bus.fmode == rs_f[p]) && (bus.wreg == rs[p]);
        assign rd_next[p] = is_x0    ? 32'd0     :
                            fwd      ? bus.wdata :
                            rs_f[p]  ? fr[rs[p]] : xr[rs[p]];
    end

    // Storage banks; writes to x0 are dropped so it always holds zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                xr[i] <= '0;
                fr[i] <= '0;
            end
        end else if (bus.wenable) begin
            if (bus.fmode)
                fr[bus.wreg] <= bus.wdata;
            else if (bus.wreg != 5'd0)
                xr[bus.wreg] <= bus.wdata;
        end
    end

    // Read results, done pulse and PC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
            done  <= 1'b0;
            pc    <= RESET_PC;
        end else begin
            done <= bus.enable;
            if (bus.enable)
                rdata <= rd_next;
            if (bus.pcenable)
                pc <= bus.next_pc;
        end
    end

    assign bus.done   = done;
    assign bus.rdata1 = rdata[0];
    assign bus.rdata2 = rdata[1];
    assign bus.rdata3 = rdata[2];
    assign bus.pc     = pc;
endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
    localparam logic [31:0] RPC = 32'h100;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    regfile_if bus();

    regfile #(.RESET_PC(RPC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_done: done=1 with no pending read");
                end else begin
                    e = q.pop_front();
                    if (bus.rdata1 !== e.d1 || bus.rdata2 !== e.d2 || bus.rdata3 !== e.d3) begin
                        bad++;
                        $display("FAIL sb_rdata: got %h %h %h want %h %h %h",
                                 bus.rdata1, bus.rdata2, bus.rdata3, e.d1, e.d2, e.d3);
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.wenable = 0; bus.fmode = 0; bus.wreg = 0; bus.wdata = 0;
        bus.pcenable = 0; bus.next_pc = 0;
        bus.enable = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rs3 = 0;
        bus.rs1_f = 0; bus.rs2_f = 0; bus.rs3_f = 0;
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic wr(input logic fm, input logic [4:0] idx, input logic [31:0] d);
        bus.wenable = 1; bus.fmode = fm; bus.wreg = idx; bus.wdata = d;
        @(negedge clk);
        bus.wenable = 0;
    endtask

    task automatic rd(input logic [4:0] r1, input logic f1, input logic [4:0] r2, input logic f2,
                      input logic [4:0] r3, input logic f3,
                      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        exp_t e;
        bus.enable = 1;
        bus.rs1 = r1; bus.rs1_f = f1;
        bus.rs2 = r2; bus.rs2_f = f2;
        bus.rs3 = r3; bus.rs3_f = f3;
        e.d1 = e1; e.d2 = e2; e.d3 = e3;
        q.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL rd_latency: done=%b want 1", bus.done);
        end
        @(negedge clk);
        bus.enable = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        idle();
        repeat (2) @(negedge clk);
        rstn = 1;
        total++;
        if (bus.pc !== RPC || bus.done !== 1'b0 || bus.rdata1 !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: pc=%h done=%b rdata1=%h want %h 0 0",
                     bus.pc, bus.done, bus.rdata1, RPC);
        end
        @(negedge clk);
        wr(0, 5, 32'hAAAA_0005);
        bus.pcenable = 1; bus.next_pc = 32'h55;
        wr(1, 5, 32'hBBBB_0005);
        bus.pcenable = 0;
        total++;
        if (bus.pc !== 32'h55) begin
            bad++;
            $display("FAIL pc_update_pre: pc=%h want 00000055", bus.pc);
        end
        // Mid-cycle reset pulse, no clock edge while low.
        #2 rstn = 0;
        #2;
        total++;
        if (bus.pc !== RPC || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: pc=%h done=%b want %h 0", bus.pc, bus.done, RPC);
        end
        rstn = 1;
        @(negedge clk);
        rd(5, 0, 5, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_basic();
        wr(0, 3, 32'hDEADBEEF);
        wr(1, 3, 32'h3F800000);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle_done: done=%b want 0", bus.done);
        end
        rd(3, 0, 3, 1, 0, 0, 32'hDEADBEEF, 32'h3F800000, 32'd0);
    endtask

    task automatic test_x0_f0();
        wr(0, 0, 32'h1234);
        wr(1, 0, 32'h5678);
        rd(0, 0, 0, 1, 3, 0, 32'd0, 32'h5678, 32'hDEADBEEF);
    endtask

    task automatic test_forward();
        exp_t e;
        wr(0, 7, 32'h1);
        wr(1, 7, 32'h77);
        // Same edge: write x7=2, read x7 twice and f7.
        bus.wenable = 1; bus.fmode = 0; bus.wreg = 7; bus.wdata = 32'h2;
        bus.enable = 1;
        bus.rs1 = 7; bus.rs1_f = 0; bus.rs2 = 7; bus.rs2_f = 0; bus.rs3 = 7; bus.rs3_f = 1;
        e.d1 = 32'h2; e.d2 = 32'h2; e.d3 = 32'h77;
        q.push_back(e);
        @(negedge clk);
        idle();
        rd(7, 0, 0, 0, 0, 0, 32'h2, 32'd0, 32'd0);
        // x0 never forwards; float write forwards only to float readers.
        bus.wenable = 1; bus.fmode = 0; bus.wreg = 0; bus.wdata = 32'h99;
        bus.enable = 1; bus.rs1 = 0; bus.rs1_f = 0;
        e.d1 = 32'd0; e.d2 = 32'd0; e.d3 = 32'd0;
        q.push_back(e);
        @(negedge clk);
        idle();
        bus.wenable = 1; bus.fmode = 1; bus.wreg = 9; bus.wdata = 32'hABC;
        bus.enable = 1;
        bus.rs1 = 9; bus.rs1_f = 1; bus.rs2 = 9; bus.rs2_f = 1; bus.rs3 = 9; bus.rs3_f = 0;
        e.d1 = 32'hABC; e.d2 = 32'hABC; e.d3 = 32'd0;
        q.push_back(e);
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] vals [3];
        vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30;
        for (int i = 0; i < 3; i++) wr(0, 5'(i + 1), vals[i]);
        bus.enable = 1;
        for (int i = 0; i < 3; i++) begin
            bus.rs1 = 5'(i + 1);
            e.d1 = vals[i]; e.d2 = 32'd0; e.d3 = 32'd0;
            q.push_back(e);
            @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b1) begin
                bad++;
                $display("FAIL b2b_done[%0d]: done=%b want 1", i, bus.done);
            end
            @(negedge clk);
        end
        bus.enable = 0;
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.rdata1 !== 32'd30) begin
            bad++;
            $display("FAIL b2b_tail: done=%b rdata1=%h want 0 0000001e", bus.done, bus.rdata1);
        end
        @(negedge clk);
    endtask

    task automatic test_pc_reset();
        bus.pcenable = 1; bus.next_pc = 32'h40;
        wr(0, 12, 32'hC0FFEE);
        bus.pcenable = 0;
        total++;
        if (bus.pc !== 32'h40) begin
            bad++;
            $display("FAIL pc_update: pc=%h want 00000040", bus.pc);
        end
        rd(12, 0, 0, 0, 0, 0, 32'hC0FFEE, 32'd0, 32'd0);
        // Read request killed by reset held across the edge.
        bus.enable = 1; bus.rs1 = 12;
        #2 rstn = 0;
        #1;
        total++;
        if (bus.pc !== RPC || bus.done !== 1'b0 || bus.rdata1 !== 32'd0) begin
            bad++;
            $display("FAIL reset_midread: pc=%h done=%b rdata1=%h want %h 0 0",
                     bus.pc, bus.done, bus.rdata1, RPC);
        end
        @(negedge clk);
        bus.enable = 0;
        rstn = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_nodone: done=%b want 0", bus.done);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0_f0();
        test_forward();
        test_back_to_back();
        test_pc_reset();
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
